// File: rtl/store_pkg.sv
// Shared types and constants for the store lane packer.
//   size_e  : encoding of the request size field (byte/half/word/illegal)
//   state_e : request sequencing FSM states
//   BE_*    : byte-enable base masks for each legal size, lane 0 aligned
package store_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane placement for a store.
//   data      : register value; only the low bytes selected by size are used
//   size      : store size
//   offset    : byte offset of the store within its word (addr[1:0])
//   wide_data : narrowed data shifted onto its lanes across two words
//   wide_mask : byte enables for the same two words (bit n covers byte n)
// An illegal size yields all-zero data and mask, so nothing is ever written.
module store_lane_shifter
  import store_pkg::*;
(
  input  logic [31:0] data,
  input  size_e       size,
  input  logic [1:0]  offset,
  output logic [63:0] wide_data,
  output logic [7:0]  wide_mask
);

  logic [31:0] narrow;
  logic [3:0]  base_mask;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    narrow    = '0;
    base_mask = '0;
    case (size)
      SIZE_BYTE: begin
        narrow    = {24'b0, data[7:0]};
        base_mask = BE_BYTE;
      end
      SIZE_HALF: begin
        narrow    = {16'b0, data[15:0]};
        base_mask = BE_HALF;
      end
      SIZE_WORD: begin
        narrow    = data;
        base_mask = BE_WORD;
      end
      default: ;
    endcase
  end

  // Shifting into a double-width vector lets a word-crossing store spill its
  // upper bytes into the second beat without any extra wrap logic.
  assign wide_data = {32'b0, narrow} << {offset, 3'b000};
  assign wide_mask = {4'b0, base_mask} << offset;

endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer: narrows a register value to byte/half/word, places it on
// the byte lanes of a 32-bit word-addressed memory bus, and splits stores that
// cross a word boundary into two aligned beats.
//   i_CLK, i_RSTn                     : clock, async active-low reset
//   i_ReqValid/o_ReqReady             : request handshake (ready only in IDLE)
//   i_ReqAddress/i_ReqData/i_ReqSize  : request fields, sampled at acceptance
//   o_MemValid/i_MemReady             : memory beat handshake
//   o_MemAddress/o_MemData/o_MemByteEnable : word-aligned beat contents
//   o_Done                            : one-cycle pulse when a request retires
//   o_Error                           : pulses with o_Done for an illegal size
module store_lane_packer
  import store_pkg::*;
#(
  parameter int p_XLEN = 32,
  parameter int p_ALEN = 32
) (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  input  logic              i_ReqValid,
  output logic              o_ReqReady,
  input  logic [p_ALEN-1:0] i_ReqAddress,
  input  logic [p_XLEN-1:0] i_ReqData,
  input  logic [1:0]        i_ReqSize,
  output logic              o_MemValid,
  input  logic              i_MemReady,
  output logic [p_ALEN-1:0] o_MemAddress,
  output logic [p_XLEN-1:0] o_MemData,
  output logic [3:0]        o_MemByteEnable,
  output logic              o_Done,
  output logic              o_Error
);

  state_e            state_q, state_d;
  logic [p_ALEN-1:0] addr_q;
  logic [63:0]       data_q;
  logic [7:0]        mask_q;
  logic              err_q;

  logic [63:0] wide_data;
  logic [7:0]  wide_mask;
  size_e       req_size;
  logic        capture;

  assign req_size = size_e'(i_ReqSize);
  assign capture  = i_ReqValid && (state_q == ST_IDLE);

  store_lane_shifter u_shifter (
    .data      (i_ReqData),
    .size      (req_size),
    .offset    (i_ReqAddress[1:0]),
    .wide_data (wide_data),
    .wide_mask (wide_mask)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the datapath registers are few and small, so
  // they are all reset to keep the bus outputs deterministic out of reset.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q <= {i_ReqAddress[p_ALEN-1:2], 2'b00};
        data_q <= wide_data;
        mask_q <= wide_mask;
        err_q  <= (req_size == SIZE_ILLEGAL);
      end
    end
  end

  // Bus outputs decode directly from the state register, so an async reset
  // drops o_MemValid immediately and beat contents stay frozen while stalled.
  always_comb begin
    state_d         = state_q;
    o_MemValid      = 1'b0;
    o_MemAddress    = '0;
    o_MemData       = '0;
    o_MemByteEnable = '0;
    o_Done          = 1'b0;
    o_Error         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ReqValid) begin
          state_d = (req_size == SIZE_ILLEGAL) ? ST_DONE : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        o_MemValid      = 1'b1;
        o_MemAddress    = addr_q;
        o_MemData       = data_q[31:0];
        o_MemByteEnable = mask_q[3:0];
        if (i_MemReady) begin
          state_d = (|mask_q[7:4]) ? ST_BEAT1 : ST_DONE;
        end
      end
      ST_BEAT1: begin
        o_MemValid      = 1'b1;
        // Wraps modulo 2^p_ALEN, so the top word's successor is address 0.
        o_MemAddress    = addr_q + p_ALEN'(4);
        o_MemData       = data_q[63:32];
        o_MemByteEnable = mask_q[7:4];
        if (i_MemReady) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        o_Done  = 1'b1;
        o_Error = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ReqReady = (state_q == ST_IDLE);

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed bench for store_lane_packer. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on the rising edge in between.
module tb_store_lane_packer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  store_lane_packer #(.p_XLEN(32), .p_ALEN(32)) dut (
    .i_CLK           (clk),
    .i_RSTn          (rst_n),
    .i_ReqValid      (req_valid),
    .o_ReqReady      (req_ready),
    .i_ReqAddress    (req_address),
    .i_ReqData       (req_data),
    .i_ReqSize       (req_size),
    .o_MemValid      (mem_valid),
    .i_MemReady      (mem_ready),
    .o_MemAddress    (mem_address),
    .o_MemData       (mem_data),
    .o_MemByteEnable (mem_be),
    .o_Done          (done),
    .o_Error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a request for one edge, then scramble the request inputs so any
  // late sampling by the DUT would show up in the beat contents.
  task automatic issue(input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size);
    @(negedge clk);
    check("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_address = addr;
    req_data    = data;
    req_size    = size;
    @(negedge clk);
    req_valid   = 1'b0;
    req_address = 32'hA5A5_A5A7;
    req_data    = 32'hFFFF_FFFF;
    req_size    = 2'b10;
  endtask

  // Called at the falling edge where the beat is expected to be presented.
  // Holds mem_ready low for 'stall' cycles checking stability, then transfers.
  task automatic beat(input string tag, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] data,
                      input int stall);
    for (int i = 0; i <= stall; i++) begin
      check({tag, "_valid"}, 32'(mem_valid), 32'd1);
      check({tag, "_addr"}, mem_address, addr);
      check({tag, "_be"}, 32'(mem_be), 32'(be));
      check({tag, "_data"}, mem_data, data);
      check({tag, "_no_done"}, 32'(done), 32'd0);
      check({tag, "_busy"}, 32'(req_ready), 32'd0);
      mem_ready = (i == stall);
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  // Called at the falling edge where the DONE pulse is expected.
  task automatic retire(input string tag, input logic exp_error);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(exp_error));
    check({tag, "_done_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_error_once"}, 32'(error), 32'd0);
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_address = '0;
    req_data    = '0;
    req_size    = '0;
    mem_ready   = 1'b0;

    // Reset state, with a request offered that must not be captured.
    @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_data", mem_data, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(mem_valid), 32'd0);

    // SW aligned.
    issue(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
    beat("sw_aligned", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0);
    retire("sw_aligned", 1'b0);

    // SB into lane 3.
    issue(32'h0000_0203, 32'h1234_56AB, 2'b00);
    beat("sb_lane3", 32'h0000_0200, 4'b1000, 32'hAB00_0000, 0);
    retire("sb_lane3", 1'b0);

    // SH into upper half; sign bits of the source are not carried.
    issue(32'h0000_0302, 32'hFFFF_8001, 2'b01);
    beat("sh_upper", 32'h0000_0300, 4'b1100, 32'h8001_0000, 0);
    retire("sh_upper", 1'b0);

    // Misaligned SW crossing a word, stalled three cycles on each beat.
    issue(32'h0000_0401, 32'h1122_3344, 2'b10);
    beat("sw_split_b0", 32'h0000_0400, 4'b1110, 32'h2233_4400, 3);
    beat("sw_split_b1", 32'h0000_0404, 4'b0001, 32'h0000_0011, 3);
    retire("sw_split", 1'b0);

    // SH at the top of the address space; second beat wraps to 0.
    issue(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
    beat("sh_wrap_b0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 0);
    beat("sh_wrap_b1", 32'h0000_0000, 4'b0001, 32'h0000_00BE, 1);
    retire("sh_wrap", 1'b0);

    // Illegal size: no beat, done and error together.
    issue(32'h0000_0500, 32'h5555_5555, 2'b11);
    check("illegal_no_valid", 32'(mem_valid), 32'd0);
    retire("illegal", 1'b1);

    // Misaligned SW, then reset asserted in the middle of the second beat.
    issue(32'h0000_0401, 32'h1122_3344, 2'b10);
    beat("rst_mid_b0", 32'h0000_0400, 4'b1110, 32'h2233_4400, 0);
    check("rst_mid_b1_valid", 32'(mem_valid), 32'd1);
    check("rst_mid_b1_be", 32'(mem_be), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid_async", 32'(mem_valid), 32'd0);
    check("rst_mid_be_async", 32'(mem_be), 32'd0);
    check("rst_mid_no_done", 32'(done), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_after_no_done", 32'(done), 32'd0);
      check("rst_after_no_valid", 32'(mem_valid), 32'd0);
      check("rst_after_ready", 32'(req_ready), 32'd1);
    end
    mem_ready = 1'b0;

    // Unit is usable again after the abort.
    issue(32'h0000_0600, 32'h0000_00C3, 2'b00);
    beat("sb_after_rst", 32'h0000_0600, 4'b0001, 32'h0000_00C3, 0);
    retire("sb_after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_lane_packer.md
Name: store_lane_packer

Overview:
- Store-path counterpart of the load-path sign/zero extender. It narrows a register value to byte, halfword or word and places it on the correct byte lanes of a 32-bit word-addressed data memory bus with byte enables.
- Misaligned stores that cross a word boundary are split into two sequential aligned bus beats.
- Sits between the execute/memory stage and the data memory port, with a valid/ready handshake on both sides.

Parameters:
- p_XLEN, 32, register/data width in bits; fixed at 32, other values unsupported. Lane count is p_XLEN/8 = 4.
- p_ALEN, 32, address width in bits.

Ports:
- i_CLK  input  1  system clock, rising edge.
- i_RSTn  input  1  asynchronous active-low reset.
- i_ReqValid  input  1  store request valid.
- o_ReqReady  output  1  unit can accept a request.
- i_ReqAddress  input  p_ALEN  byte address of the store.
- i_ReqData  input  p_XLEN  register value; low bits are used.
- i_ReqSize  input  2  00 byte, 01 half, 10 word, 11 illegal.
- o_MemValid  output  1  bus beat valid.
- i_MemReady  input  1  memory accepts the beat.
- o_MemAddress  output  p_ALEN  word-aligned beat address (bits [1:0] always 0).
- o_MemData  output  p_XLEN  lane-positioned write data.
- o_MemByteEnable  output  4  per-lane write enable; bit n covers data[8n+7:8n].
- o_Done  output  1  one-cycle pulse when the request retires.
- o_Error  output  1  one-cycle pulse alongside o_Done for an illegal size.

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1, DONE. Reset forces IDLE asynchronously and clears all datapath registers.
- Reset values:
  - o_MemValid=0, o_Done=0, o_Error=0, o_MemAddress=0, o_MemData=0, o_MemByteEnable=0.
  - o_ReqReady = (state==IDLE).
  - No capture happens while i_RSTn=0.
- IDLE: when i_ReqValid & o_ReqReady at a clock edge, capture the request.
  - Narrow the data: byte → data[7:0], half → data[15:0], word → data[31:0]; upper bits zeroed.
  - Base mask: 0001, 0011 or 1111.
  - off = addr[1:0]. Wide data (64b) = narrow << (8*off). Wide mask (8b) = base << off.
  - Word address A = addr & ~3.
  - Next state is BEAT0, or DONE with the error flag set if size = 11.
- BEAT0: o_MemValid=1, o_MemAddress=A, o_MemData=wide[31:0], o_MemByteEnable=mask[3:0].
  - Outputs are held stable until i_MemReady.
  - On transfer, go to BEAT1 if mask[7:4]!=0, else DONE.
- BEAT1: o_MemAddress=A+4 (mod 2^p_ALEN; 0xFFFFFFFC wraps to 0), o_MemData=wide[63:32], o_MemByteEnable=mask[7:4].
  - Holds until i_MemReady, then goes to DONE.
- DONE: o_Done=1 for exactly one cycle, o_Error=1 if illegal, o_MemValid=0, o_ReqReady=0; next state IDLE.
- Latency:
  - Aligned or non-crossing store: o_MemValid rises the cycle after acceptance; o_Done comes the cycle after the beat transfers.
  - Minimum 3 cycles per request.
- Disabled lanes on o_MemData are 0. o_MemValid is never asserted for an illegal size.
- o_MemValid may not drop without a transfer, except on reset.
- Reset mid-beat: o_MemValid drops immediately (asynchronously), the request is discarded, and no o_Done is produced.
- Request fields are sampled only at acceptance; later changes to the i_Req* inputs are ignored.

Decomposition:
- Package store_pkg holds:
  - typedef enum for size (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_ILLEGAL);
  - typedef enum for FSM state;
  - constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
- One combinational sub-module, store_lane_shifter: takes data, size and offset; produces the 64b wide data and 8b wide mask. The FSM and registers stay in the top.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF → one beat: addr 0x100, BE 1111, data 0xDEADBEEF; o_Done one cycle later; o_Error=0.
- SB addr 0x203 data 0x123456AB → one beat: addr 0x200, BE 1000, data 0xAB000000.
- SH addr 0x302 data 0xFFFF8001 → one beat: addr 0x300, BE 1100, data 0x80010000.
- SW addr 0x401 data 0x11223344, with i_MemReady low 3 cycles on each beat → beat0: addr 0x400, BE 1110, data 0x22334400; beat1: addr 0x404, BE 0001, data 0x00000011. Outputs stay stable while stalled; exactly one o_Done.
- SH addr 0xFFFFFFFF data 0x0000BEEF → beat0: addr 0xFFFFFFFC, BE 1000, data 0xEF000000; beat1: addr 0x00000000, BE 0001, data 0x000000BE.
- Size 11 → no o_MemValid; o_Done and o_Error pulse together. Then issue a misaligned SW and deassert i_RSTn during BEAT1 → o_MemValid falls immediately, no o_Done, state returns to IDLE with o_ReqReady=1 after reset.
